// File: rtl/vga_scanout_if.sv
// Framebuffer read port and VGA pin bundle for vga_scanout.
// The master side is the scanout engine; the slave side is the framebuffer RAM plus the DAC pins.
interface vga_scanout_if;
    logic [14:0] rd_address;
    logic [2:0]  rd_data;
    logic        vga_clk;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vblank;
    logic        frame_start;

    modport master (
        output rd_address,
        input  rd_data,
        output vga_clk,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hs,
        output vga_vs,
        output vga_blank_n,
        output vblank,
        output frame_start
    );

    modport slave (
        input  rd_address,
        output rd_data,
        input  vga_clk,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hs,
        input  vga_vs,
        input  vga_blank_n,
        input  vblank,
        input  frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 Hz scanout of a 160x120x3 framebuffer with 4x4 pixel replication.
// Two-stage pipeline: stage A issues the read address, stage B turns the returned pixel into DAC levels.
module vga_scanout #(
    parameter int CLOCK_DIV = 2,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic          clk,
    input  logic          reset,
    vga_scanout_if.master vga_bus
);
    localparam int DIV_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLOCK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    // y*160 + x as y*128 + y*32 + x; stays inside 15 bits for the whole 160x120 map.
    function automatic logic [14:0] pixel_address(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] y_ext;
        y_ext = {8'd0, y};
        return (y_ext << 3'd7) + (y_ext << 3'd5) + {7'd0, x};
    endfunction

    logic [DIV_W-1:0] div_r;
    logic [9:0]       h_count_r;
    logic [9:0]       v_count_r;
    logic             vga_clk_r;
    logic [14:0]      rd_address_r;
    logic             hs_a_r;
    logic             vs_a_r;
    logic             vis_a_r;
    logic [7:0]       red_r;
    logic [7:0]       green_r;
    logic [7:0]       blue_r;
    logic             hs_r;
    logic             vs_r;
    logic             blank_n_r;
    logic             frame_start_r;

    logic             pix_en_s;
    logic [DIV_W-1:0] div_next_s;
    logic [9:0]       h_next_s;
    logic [9:0]       v_next_s;
    logic             visible_s;
    logic             hs_raw_s;
    logic             vs_raw_s;
    logic             vblank_s;
    logic [14:0]      address_s;

    // Next-state of the clock divider and the beam counters.
    always_comb begin
        pix_en_s   = (div_r == DIV_LAST);
        div_next_s = div_r;
        h_next_s   = h_count_r;
        v_next_s   = v_count_r;
        if (pix_en_s) begin
            div_next_s = DIV_ZERO;
            if (h_count_r == H_LAST) begin
                h_next_s = 10'd0;
                if (v_count_r == V_LAST) begin
                    v_next_s = 10'd0;
                end else begin
                    v_next_s = v_count_r + 10'd1;
                end
            end else begin
                h_next_s = h_count_r + 10'd1;
            end
        end else begin
            div_next_s = div_r + DIV_ONE;
        end
    end

    // Raw timing flags and the framebuffer address for the current beam position.
    always_comb begin
        visible_s = (h_count_r < H_VISIBLE) && (v_count_r < V_VIS);
        hs_raw_s  = !((h_count_r >= H_SYNC_START) && (h_count_r < H_SYNC_END));
        vs_raw_s  = !((v_count_r >= V_SYNC_START) && (v_count_r < V_SYNC_END));
        vblank_s  = (v_count_r >= V_VIS);
        if (visible_s) begin
            address_s = pixel_address(h_count_r[9:2], v_count_r[8:2]);
        end else begin
            address_s = 15'd0;
        end
    end

    // Divider, beam counters and the DAC pixel clock (high for the first half of each pixel).
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r     <= DIV_ZERO;
            h_count_r <= 10'd0;
            v_count_r <= 10'd0;
            vga_clk_r <= 1'b0;
        end else begin
            div_r     <= div_next_s;
            h_count_r <= h_next_s;
            v_count_r <= v_next_s;
            vga_clk_r <= (div_next_s < DIV_HALF);
        end
    end

    // Stage A: read address plus timing flags that must travel alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_address_r <= 15'd0;
            hs_a_r       <= 1'b1;
            vs_a_r       <= 1'b1;
            vis_a_r      <= 1'b0;
        end else begin
            rd_address_r <= address_s;
            hs_a_r       <= hs_raw_s;
            vs_a_r       <= vs_raw_s;
            vis_a_r      <= visible_s;
        end
    end

    // Stage B: colour expansion gated by the delayed visible flag, sync/blank realignment.
    always_ff @(posedge clk) begin
        if (reset) begin
            red_r         <= 8'h00;
            green_r       <= 8'h00;
            blue_r        <= 8'h00;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            blank_n_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            if (vis_a_r) begin
                red_r   <= {8{vga_bus.rd_data[2]}};
                green_r <= {8{vga_bus.rd_data[1]}};
                blue_r  <= {8{vga_bus.rd_data[0]}};
            end else begin
                red_r   <= 8'h00;
                green_r <= 8'h00;
                blue_r  <= 8'h00;
            end
            hs_r          <= hs_a_r;
            vs_r          <= vs_a_r;
            blank_n_r     <= vis_a_r;
            frame_start_r <= pix_en_s && (h_count_r == 10'd0) && (v_count_r == V_VIS);
        end
    end

    assign vga_bus.rd_address  = rd_address_r;
    assign vga_bus.vga_clk     = vga_clk_r;
    assign vga_bus.vga_r       = red_r;
    assign vga_bus.vga_g       = green_r;
    assign vga_bus.vga_b       = blue_r;
    assign vga_bus.vga_hs      = hs_r;
    assign vga_bus.vga_vs      = vs_r;
    assign vga_bus.vga_blank_n = blank_n_r;
    assign vga_bus.vblank      = vblank_s;
    assign vga_bus.frame_start = frame_start_r;
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Reader side of the 160x120, 3-bit-per-pixel framebuffer that the drawing datapaths fill through their pixel/colour port. Generates 640x480@60 Hz VGA timing from the 50 MHz system clock, fetches each framebuffer pixel through a 1-cycle-latency read port with 4x4 pixel replication, and drives the DAC, sync and blank pins. Exports `vblank` and `frame_start` so the drawing FSMs can restrict redraws to vertical blank and avoid tearing.

## Interface
- `CLOCK_DIV`, 2: system clocks per VGA pixel; counters advance only on pixel-enable cycles.
- `clk`  in  1  system clock (50 MHz); one clock domain.
- `reset`  in  1  synchronous, active-high.
- `rd_address`  out  15  framebuffer read address, `y*160 + x`.
- `rd_data`  in  3  framebuffer read data; valid 1 clk after `rd_address`. Bit mapping: [2]=R, [1]=G, [0]=B.
- `vga_clk`  out  1  pixel clock to DAC; rises on the pixel-enable cycle.
- `vga_r`, `vga_g`, `vga_b`  out  8 each  colour; each bit expands to 8'hFF or 8'h00.
- `vga_hs`, `vga_vs`  out  1  sync, active-low.
- `vga_blank_n`  out  1  low outside the 640x480 visible region.
- `vblank`  out  1  high while `vcount` is in 480..524.
- `frame_start`  out  1  one-clk pulse on the pixel-enable cycle where (`hcount`, `vcount`) becomes (0, 480).

## Operation
- Divider: `div` counts 0..CLOCK_DIV-1. `pix_en` = (`div` == CLOCK_DIV-1). `vga_clk` is high for the first half of each pixel period.
- `hcount` 0..799: wraps to 0 on `pix_en` at 799; `vcount` 0..524 advances on that wrap, then wraps to 0 after 524.
- Horizontal: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Address: `x` = `hcount[9:2]` (0..159), `y` = `vcount[8:2]` (0..119).
  - `rd_address` = (`y`<<7)+(`y`<<5)+`x`, computed in 15 bits; no overflow, max 19199.
  - Outside the visible region `rd_address` holds 0.
- Pipeline: stage A registers `rd_address` and the raw hs/vs/visible flags from the counters. Stage B registers the outputs from `rd_data` and the stage-A flags.
- Colour outputs are forced to 0 whenever the delayed visible flag is 0, regardless of `rd_data`.
- `vblank` is combinational from `vcount` (undelayed). `frame_start` is registered.

## Timing
- Reset values:
  - `div`, `hcount`, `vcount` = 0.
  - `rd_address` = 0.
  - RGB = 0.
  - `vga_hs` = `vga_vs` = 1.
  - `vga_blank_n` = 0.
  - `vblank` = 0.
  - `frame_start` = 0.
  - `vga_clk` = 0.
- Reset mid-frame: all of the above apply on the next edge. The first `pix_en` after release is CLOCK_DIV clks later, at (0,0).
- Latency:
  - `rd_address` is 1 clk after the counter value.
  - RGB, `vga_hs`, `vga_vs` and `vga_blank_n` are 2 clk after the counter value, all aligned.
  - With CLOCK_DIV=2 the outputs stay stable for the whole pixel period they belong to.
- Periods (CLOCK_DIV=2):
  - Line = 1600 clk.
  - Frame = 840000 clk.
  - `vga_hs` low for 192 clk per line.
  - `vga_vs` low for 3200 clk per frame.
- Each framebuffer pixel is read for 4 consecutive pixel periods on each of 4 consecutive lines.
- No handshake: `rd_data` must be valid 1 clk after the address, always; the read port is never stalled.

## Test plan
- Reset held 5 clk, then released:
  - `hcount` steps every 2 clk.
  - `rd_address` = 0 after 1 clk.
  - `vga_blank_n` = 1 after 2 clk.
  - `vga_hs` = `vga_vs` = 1.
- Line timing, over one full line:
  - `vga_hs` falls 2 clk after `hcount` reaches 656.
  - `vga_hs` stays low exactly 192 clk.
  - `vga_blank_n` low exactly 320 clk.
  - Line period 1600 clk.
- Frame timing:
  - `vga_vs` low during lines 490-491 (3200 clk).
  - `frame_start` pulses once per 840000 clk, at `vcount` = 480, `hcount` = 0.
  - `vblank` high for 45 lines.
- Address map: at `hcount` = 13, `vcount` = 9, `rd_address` = 323. With the framebuffer model returning `rd_address[2:0]` = 3 (3'b011), RGB = 00/FF/FF on the matching output cycle.
- Colour expansion and blanking:
  - `rd_data` tied to 3'b101 gives R = FF, G = 00, B = FF in the visible region.
  - All outputs are 0 at `hcount` 640-799 and `vcount` 480-524.
- Mid-frame reset: assert `reset` at (300,200) for 1 clk.
  - The next edge shows the reset values.
  - Counting restarts from (0,0).
  - The next `frame_start` comes 480*1600 + 2 clk after release.
